fft4_stream: RTL and testbench
==============================

Name: fft4_stream

Overview:
Streaming 4-point radix-2 DIT FFT engine, the parametrised successor of the team's combinational/registered 4-point FFT core. It accepts complex samples serially over a valid/ready handshake, buffers one frame of 4, computes the transform in a 2-stage registered datapath at full internal precision, then emits X0..X3 serially with per-frame selectable output scaling and saturation reporting. It sits between the sample front-end and downstream spectral logic.

Parameters:
WIDTH, 8, signed two's-complement width of each input/output real and imag component (valid range 4..16)
SCALE_SHIFT, 2, arithmetic right shift applied to results when scale_mode=1 (valid range 0..2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  engine can accept a sample
in_real  in  WIDTH  sample real part, signed
in_imag  in  WIDTH  sample imag part, signed
scale_mode  in  1  0 = saturate unscaled result; 1 = shift right by SCALE_SHIFT, then saturate
out_valid  out  1  output bin valid
out_ready  in  1  downstream accepts bin
out_real  out  WIDTH  bin real part, signed
out_imag  out  WIDTH  bin imag part, signed
out_index  out  2  bin index k of current output (0..3)
out_sat  out  1  either component of current bin saturated
frame_done  out  1  one-cycle pulse on the handshake of bin 3

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_real=0, out_imag=0, out_index=0, out_sat=0, frame_done=0; sample counter=0.
- States: LOAD -> STAGE1 -> STAGE2 -> UNLOAD -> LOAD.
- LOAD: in_ready=1. Each cycle with in_valid&in_ready stores the sample at x[cnt], cnt++. scale_mode is latched on the cycle x[0] is accepted and held for the whole frame. The handshake of x[3] (cycle c) moves to STAGE1.
- STAGE1 (c+1): in_ready=0. Registers a0=x0+x2, a1=x0-x2, b0=x1+x3, b1=x1-x3, each component WIDTH+1 bits.
- STAGE2 (c+2): registers X0=a0+b0; X2=a0-b0; X1r=a1r+b1i, X1i=a1i-b1r; X3r=a1r-b1i, X3i=a1i+b1r; each component WIDTH+2 bits, no truncation. X1 and X3 use the -j twiddle as swap/negate only; no multiplier.
- UNLOAD (from c+3): out_valid=1, bins emitted in order k=0,1,2,3 with out_index=k. Each bin holds stable while out_valid&!out_ready. Advance on out_valid&out_ready. Minimum latency from the x[3] handshake to bin 0 valid is 3 cycles.
- After the bin 3 handshake: frame_done=1 for that cycle, then next cycle state=LOAD, out_valid=0, in_ready=1. There is no input/output overlap; the engine holds one frame at a time.
- Output scaling: v = full-precision value; mode 0: r = v; mode 1: r = v >>> SCALE_SHIFT (floor). Then r is saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. out_sat=1 if real or imag was clipped. Scaling and saturation are registered with the bin; they must not add latency.
- in_valid during non-LOAD states is ignored; no sample is consumed.
- out_ready while out_valid=0 is ignored.
- rst asserted mid-frame, in any state, discards the partial or complete frame; all outputs take reset values on the next edge.
- scale_mode changes mid-frame have no effect until the next frame's x[0].

Test Plan:
- Impulse: x=[(10,0),(0,0),(0,0),(0,0)], mode0, out_ready=1 -> bins 0..3 all (10,0), out_index 0,1,2,3, out_sat=0; bin 0 valid exactly 3 cycles after the x[3] handshake; frame_done pulses on bin 3.
- DC with scaling: four samples of (20,-8); mode0 -> X0=(80,-32), X1..X3=(0,0); repeat with mode1, SCALE_SHIFT=2 -> X0=(20,-8), others (0,0).
- Odd tone: x real=[0,10,0,-10], imag=0 -> X0=(0,0), X1=(0,-20), X2=(0,0), X3=(0,20).
- Saturation: four samples of (100,-100), mode0, WIDTH=8 -> X0=(127,-128), out_sat=1; bins 1..3 = (0,0), out_sat=0. Same frame in mode1 -> X0=(100,-100), out_sat=0.
- Backpressure and flow: out_ready low for 5 cycles during bin 1 -> bin 1 held stable with out_index=1; in_ready=0 throughout UNLOAD; in_valid pulses during STAGE1/2 are not consumed; second frame is accepted only after frame_done.
- Reset mid-operation: rst asserted after 2 samples are loaded, and separately during UNLOAD at bin 2 -> next cycle out_valid=0, in_ready=1; a fresh impulse frame then produces correct output with no residue from the aborted frame.

Source files
------------

// File: rtl/fft4_stream_if.sv
// Sample-in / bin-out handshake bundle for the streaming 4-point FFT engine.
// The master side is the producer/consumer around the engine; the slave side is the engine.
interface fft4_stream_if #(
  parameter int WIDTH = 8
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_real;
  logic signed [WIDTH-1:0] in_imag;
  logic                    scale_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_real;
  logic signed [WIDTH-1:0] out_imag;
  logic [1:0]              out_index;
  logic                    out_sat;
  logic                    frame_done;

  modport master (
    output in_valid, in_real, in_imag, scale_mode, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_sat, frame_done
  );

  modport slave (
    input  in_valid, in_real, in_imag, scale_mode, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_sat, frame_done
  );
endinterface

// File: rtl/fft4_stream.sv
// Streaming 4-point radix-2 DIT FFT: buffers one frame of four complex samples, runs two
// registered butterfly stages at full precision, then emits X0..X3 with optional scaling.
module fft4_stream #(
  parameter int WIDTH       = 8,
  parameter int SCALE_SHIFT = 2
) (
  input  logic          clk,
  input  logic          rst,
  fft4_stream_if.slave  io_bus
);

  typedef enum logic [1:0] {LOAD, STAGE1, STAGE2, UNLOAD} state_t;

  localparam logic signed [WIDTH+1:0] MAXV = (WIDTH+2)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [WIDTH+1:0] MINV = ~MAXV;

  state_t                  r_state;
  logic [1:0]              r_cnt;
  logic                    r_scaleMode;
  logic                    r_inReady;
  logic                    r_outValid;
  logic signed [WIDTH-1:0] r_outReal;
  logic signed [WIDTH-1:0] r_outImag;
  logic [1:0]              r_outIndex;
  logic                    r_outSat;

  logic signed [WIDTH-1:0] r_xr [4];
  logic signed [WIDTH-1:0] r_xi [4];
  logic signed [WIDTH:0]   r_a0r, r_a0i, r_a1r, r_a1i, r_b0r, r_b0i, r_b1r, r_b1i;
  logic signed [WIDTH+1:0] r_binR [4];
  logic signed [WIDTH+1:0] r_binI [4];

  logic signed [WIDTH+1:0] w_xR [4];
  logic signed [WIDTH+1:0] w_xI [4];
  logic signed [WIDTH+1:0] w_srcR, w_srcI;
  logic [WIDTH:0]          w_scR, w_scI;
  logic [1:0]              w_nextIdx;
  logic signed [WIDTH+1:0] w_ea0r, w_ea0i, w_ea1r, w_ea1i, w_eb0r, w_eb0i, w_eb1r, w_eb1i;

  // Returns {clipped, value}: optional floor shift, then clamp into the WIDTH-bit range.
  function automatic logic [WIDTH:0] scaleSat(input logic signed [WIDTH+1:0] v, input logic mode);
    logic signed [WIDTH+1:0] s;
    s = mode ? (v >>> SCALE_SHIFT) : v;
    if (s > MAXV)      return {1'b1, MAXV[WIDTH-1:0]};
    else if (s < MINV) return {1'b1, MINV[WIDTH-1:0]};
    else               return {1'b0, s[WIDTH-1:0]};
  endfunction

  assign w_ea0r = {r_a0r[WIDTH], r_a0r};
  assign w_ea0i = {r_a0i[WIDTH], r_a0i};
  assign w_ea1r = {r_a1r[WIDTH], r_a1r};
  assign w_ea1i = {r_a1i[WIDTH], r_a1i};
  assign w_eb0r = {r_b0r[WIDTH], r_b0r};
  assign w_eb0i = {r_b0i[WIDTH], r_b0i};
  assign w_eb1r = {r_b1r[WIDTH], r_b1r};
  assign w_eb1i = {r_b1i[WIDTH], r_b1i};

  // The -j twiddle on the odd bins is a real/imag swap with one negation.
  assign w_xR[0] = w_ea0r + w_eb0r;
  assign w_xI[0] = w_ea0i + w_eb0i;
  assign w_xR[1] = w_ea1r + w_eb1i;
  assign w_xI[1] = w_ea1i - w_eb1r;
  assign w_xR[2] = w_ea0r - w_eb0r;
  assign w_xI[2] = w_ea0i - w_eb0i;
  assign w_xR[3] = w_ea1r - w_eb1i;
  assign w_xI[3] = w_ea1i + w_eb1r;

  // Bin 0 is taken straight from the stage-2 sums so scaling adds no cycle.
  assign w_nextIdx = r_outIndex + 2'd1;
  assign w_srcR    = (r_state == STAGE2) ? w_xR[0] : r_binR[w_nextIdx];
  assign w_srcI    = (r_state == STAGE2) ? w_xI[0] : r_binI[w_nextIdx];
  assign w_scR     = scaleSat(w_srcR, r_scaleMode);
  assign w_scI     = scaleSat(w_srcI, r_scaleMode);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_cnt       <= 2'd0;
      r_scaleMode <= 1'b0;
      r_inReady   <= 1'b1;
      r_outValid  <= 1'b0;
      r_outReal   <= '0;
      r_outImag   <= '0;
      r_outIndex  <= 2'd0;
      r_outSat    <= 1'b0;
    end else begin
      unique case (r_state)
        LOAD: begin
          if (io_bus.in_valid) begin
            r_xr[r_cnt] <= io_bus.in_real;
            r_xi[r_cnt] <= io_bus.in_imag;
            r_cnt       <= r_cnt + 2'd1;
            if (r_cnt == 2'd0) r_scaleMode <= io_bus.scale_mode;
            if (r_cnt == 2'd3) begin
              r_state   <= STAGE1;
              r_inReady <= 1'b0;
            end
          end
        end
        STAGE1: begin
          r_a0r   <= {r_xr[0][WIDTH-1], r_xr[0]} + {r_xr[2][WIDTH-1], r_xr[2]};
          r_a0i   <= {r_xi[0][WIDTH-1], r_xi[0]} + {r_xi[2][WIDTH-1], r_xi[2]};
          r_a1r   <= {r_xr[0][WIDTH-1], r_xr[0]} - {r_xr[2][WIDTH-1], r_xr[2]};
          r_a1i   <= {r_xi[0][WIDTH-1], r_xi[0]} - {r_xi[2][WIDTH-1], r_xi[2]};
          r_b0r   <= {r_xr[1][WIDTH-1], r_xr[1]} + {r_xr[3][WIDTH-1], r_xr[3]};
          r_b0i   <= {r_xi[1][WIDTH-1], r_xi[1]} + {r_xi[3][WIDTH-1], r_xi[3]};
          r_b1r   <= {r_xr[1][WIDTH-1], r_xr[1]} - {r_xr[3][WIDTH-1], r_xr[3]};
          r_b1i   <= {r_xi[1][WIDTH-1], r_xi[1]} - {r_xi[3][WIDTH-1], r_xi[3]};
          r_state <= STAGE2;
        end
        STAGE2: begin
          for (int k = 0; k < 4; k++) begin
            r_binR[k] <= w_xR[k];
            r_binI[k] <= w_xI[k];
          end
          r_outValid <= 1'b1;
          r_outIndex <= 2'd0;
          r_outReal  <= w_scR[WIDTH-1:0];
          r_outImag  <= w_scI[WIDTH-1:0];
          r_outSat   <= w_scR[WIDTH] | w_scI[WIDTH];
          r_state    <= UNLOAD;
        end
        UNLOAD: begin
          if (io_bus.out_ready) begin
            if (r_outIndex == 2'd3) begin
              r_state    <= LOAD;
              r_inReady  <= 1'b1;
              r_outValid <= 1'b0;
              r_outIndex <= 2'd0;
              r_outReal  <= '0;
              r_outImag  <= '0;
              r_outSat   <= 1'b0;
            end else begin
              r_outIndex <= w_nextIdx;
              r_outReal  <= w_scR[WIDTH-1:0];
              r_outImag  <= w_scI[WIDTH-1:0];
              r_outSat   <= w_scR[WIDTH] | w_scI[WIDTH];
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign io_bus.in_ready   = r_inReady;
  assign io_bus.out_valid  = r_outValid;
  assign io_bus.out_real   = r_outReal;
  assign io_bus.out_imag   = r_outImag;
  assign io_bus.out_index  = r_outIndex;
  assign io_bus.out_sat    = r_outSat;
  assign io_bus.frame_done = r_outValid & io_bus.out_ready & (r_outIndex == 2'd3);

endmodule

// File: tb/tb_fft4_stream.sv
// Self-checking bench for fft4_stream: directed frames plus random frames, each compared
// against a direct DFT of the loaded samples with the scaling/clipping rules applied.
module tb_fft4_stream;
  localparam int W     = 8;
  localparam int SHIFT = 2;
  localparam int MAXO  = (1 << (W-1)) - 1;
  localparam int MINO  = -(1 << (W-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   fr [4];
  int   fi [4];
  int   expR [4];
  int   expI [4];
  bit   expS [4];

  fft4_stream_if #(.WIDTH(W)) bus ();

  fft4_stream #(.WIDTH(W), .SCALE_SHIFT(SHIFT)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int refScale(input int v, input bit mode, inout bit sat);
    int d;
    int r;
    d = 1 << SHIFT;
    r = v;
    if (mode) r = (v >= 0) ? v / d : -((-v + d - 1) / d);
    if (r > MAXO) begin r = MAXO; sat = 1'b1; end
    else if (r < MINO) begin r = MINO; sat = 1'b1; end
    return r;
  endfunction

  // X[k] = sum_n x[n] * (-j)^(n*k), then scaled and clipped per component.
  task automatic computeRef(input bit mode);
    for (int k = 0; k < 4; k++) begin
      int sr = 0;
      int si = 0;
      bit s  = 1'b0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: begin sr += fr[n];  si += fi[n];  end
          1: begin sr += fi[n];  si -= fr[n];  end
          2: begin sr -= fr[n];  si -= fi[n];  end
          default: begin sr -= fi[n]; si += fr[n]; end
        endcase
      end
      expR[k] = refScale(sr, mode, s);
      expI[k] = refScale(si, mode, s);
      expS[k] = s;
    end
  endtask

  task automatic setFrame(input int r0, i0, r1, i1, r2, i2, r3, i3);
    fr[0] = r0; fi[0] = i0; fr[1] = r1; fi[1] = i1;
    fr[2] = r2; fi[2] = i2; fr[3] = r3; fi[3] = i3;
  endtask

  // Entered and left at negedge+1. stallBin/abortBin of 4 means none.
  task automatic applyStimulus(input bit mode, input int stallBin, input int stallLen,
                               input int abortBin, input bit gaps);
    int lat;
    computeRef(mode);
    for (int n = 0; n < 4; n++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk); #1;
      end
      bus.in_valid   = 1'b1;
      bus.in_real    = W'(fr[n]);
      bus.in_imag    = W'(fi[n]);
      bus.scale_mode = (n == 0) ? mode : ~mode;
      #1 checkOutput("in_ready_load", bus.in_ready, 1);
      @(posedge clk); @(negedge clk); #1;
    end
    // Junk samples and a flipped mode while busy must not disturb the frame.
    bus.in_real    = W'($urandom);
    bus.in_imag    = W'($urandom);
    bus.scale_mode = ~mode;
    bus.out_ready  = 1'b1;
    lat = 1;
    #1;
    while (bus.out_valid !== 1'b1 && lat < 8) begin
      checkOutput("in_ready_stage", bus.in_ready, 0);
      @(posedge clk); @(negedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, 3);
    for (int k = 0; k < 4; k++) begin
      if (k == abortBin) begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_in_ready", bus.in_ready, 1);
        checkOutput("abort_out_index", bus.out_index, 0);
        rst = 1'b0;
        return;
      end
      if (k == stallBin) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stallLen; s++) begin
          #1;
          checkOutput("stall_valid", bus.out_valid, 1);
          checkOutput("stall_index", bus.out_index, k);
          checkOutput("stall_real", bus.out_real, expR[k]);
          checkOutput("stall_imag", bus.out_imag, expI[k]);
          checkOutput("stall_frame_done", bus.frame_done, 0);
          @(posedge clk); @(negedge clk); #1;
        end
      end
      bus.out_ready = 1'b1;
      #1;
      checkOutput("out_valid", bus.out_valid, 1);
      checkOutput("out_index", bus.out_index, k);
      checkOutput("out_real", bus.out_real, expR[k]);
      checkOutput("out_imag", bus.out_imag, expI[k]);
      checkOutput("out_sat", bus.out_sat, expS[k]);
      checkOutput("in_ready_unload", bus.in_ready, 0);
      checkOutput("frame_done", bus.frame_done, (k == 3) ? 1 : 0);
      if (k == 3) bus.in_valid = 1'b0;
      @(posedge clk); @(negedge clk); #1;
    end
    checkOutput("post_out_valid", bus.out_valid, 0);
    checkOutput("post_in_ready", bus.in_ready, 1);
    checkOutput("post_frame_done", bus.frame_done, 0);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_real    = '0;
    bus.in_imag    = '0;
    bus.scale_mode = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_real", bus.out_real, 0);
    checkOutput("rst_out_imag", bus.out_imag, 0);
    checkOutput("rst_out_index", bus.out_index, 0);
    checkOutput("rst_out_sat", bus.out_sat, 0);
    checkOutput("rst_frame_done", bus.frame_done, 0);
    rst = 1'b0;

    $display("[TB] impulse");
    setFrame(10, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 4, 0, 4, 1'b0);

    $display("[TB] DC unscaled and scaled");
    setFrame(20, -8, 20, -8, 20, -8, 20, -8);
    applyStimulus(1'b0, 4, 0, 4, 1'b0);
    applyStimulus(1'b1, 4, 0, 4, 1'b0);

    $display("[TB] odd tone");
    setFrame(0, 0, 10, 0, 0, 0, -10, 0);
    applyStimulus(1'b0, 4, 0, 4, 1'b0);

    $display("[TB] saturation");
    setFrame(100, -100, 100, -100, 100, -100, 100, -100);
    applyStimulus(1'b0, 4, 0, 4, 1'b0);
    applyStimulus(1'b1, 4, 0, 4, 1'b0);

    $display("[TB] backpressure on bin 1");
    setFrame(3, 7, -5, 2, 9, -1, 4, 6);
    applyStimulus(1'b0, 1, 5, 4, 1'b0);

    $display("[TB] reset after two samples");
    for (int n = 0; n < 2; n++) begin
      bus.in_valid = 1'b1;
      bus.in_real  = W'(50 + n);
      bus.in_imag  = W'(-30);
      @(posedge clk); @(negedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    checkOutput("rst_load_in_ready", bus.in_ready, 1);
    checkOutput("rst_load_out_valid", bus.out_valid, 0);
    rst = 1'b0;
    setFrame(10, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 4, 0, 4, 1'b0);

    $display("[TB] reset during unload at bin 2");
    setFrame(60, 20, -40, 10, 30, -50, 15, 5);
    applyStimulus(1'b0, 4, 0, 2, 1'b0);
    setFrame(10, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 4, 0, 4, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 16; f++) begin
      for (int n = 0; n < 4; n++) begin
        if (f % 4 == 0) begin
          fr[n] = ($urandom_range(0, 1) == 1) ? MAXO : MINO;
          fi[n] = ($urandom_range(0, 1) == 1) ? MAXO : MINO;
        end else begin
          fr[n] = int'($urandom_range(0, 255)) - 128;
          fi[n] = int'($urandom_range(0, 255)) - 128;
        end
      end
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                    int'($urandom_range(1, 3)), 4, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
